fc_feature_feeder: RTL

Upstream feeder for the fully-connected classifier stage. Accepts one pooled convolution feature per handshake and applies ReLU plus a shift-and-saturate requantisation to signed 8-bit. Buffers all 64 features, then streams them to the FC stage as four lanes per cycle for 16 cycles. Drives the FC enable, waits for the FC completion flag, captures the class, and drops the enable for one cycle so the FC clears before the next frame.

---
 rtl/fc_feature_feeder_pkg.sv | 28 ++
 rtl/fc_feature_feeder_if.sv | 30 +++
 rtl/fc_feature_feeder_requant.sv | 28 ++
 rtl/fc_feature_feeder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fc_feature_feeder_pkg.sv
// Shared constants, class codes and state encoding for the FC feature feeder
// and the FC stage it drives.
package fc_pkg;

    localparam int FC_N_FEAT  = 64;
    localparam int FC_LANES   = 4;
    localparam int FC_GROUPS  = FC_N_FEAT / FC_LANES;
    localparam int FC_FEAT_W  = 8;
    localparam int FC_IN_W    = 16;
    localparam int FC_SHIFT   = 4;
    localparam int FC_TIMEOUT = 8;

    localparam logic [1:0] CLASS_NORMAL   = 2'd0;
    localparam logic [1:0] CLASS_ABNORMAL = 2'd1;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_STREAM,
        ST_WAIT,
        ST_DRAIN
    } fc_state_e;

    // Counter width helper that never returns 0, so 1-deep counters stay legal.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fc_feature_feeder_if.sv
// Upstream feature handshake, FC-stage lanes/flag and result signals of the feeder.
interface fc_feature_feeder_if
    import fc_pkg::*;
#(
    parameter int IN_W  = FC_IN_W,
    parameter int LANES = FC_LANES
);

    logic                                  feat_valid;
    logic signed [IN_W-1:0]                feat_data;
    logic                                  feat_ready;
    logic                                  fc_en;
    logic signed [LANES-1:0][FC_FEAT_W-1:0] fc_in;
    logic                                  fc_flag;
    logic [1:0]                            fc_class;
    logic                                  result_valid;
    logic [1:0]                            result_class;
    logic                                  err;

    modport master (
        input  feat_valid, feat_data, fc_flag, fc_class,
        output feat_ready, fc_en, fc_in, result_valid, result_class, err
    );

    modport slave (
        output feat_valid, feat_data, fc_flag, fc_class,
        input  feat_ready, fc_en, fc_in, result_valid, result_class, err
    );

endinterface

// File: rtl/fc_feature_feeder_requant.sv
// ReLU followed by arithmetic right shift and saturation to the positive range
// of a signed OUT_W-bit value.
module feat_requant #(
    parameter int IN_W  = 16,
    parameter int SHIFT = 4,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0] x,
    output logic [OUT_W-1:0]       y
);

    logic signed [IN_W-1:0] sh;

    assign sh = x >>> SHIFT;

    // Any set bit at or above OUT_W-1 means the shifted value exceeds max positive.
    always_comb begin
        y = '0;
        if (x[IN_W-1]) begin
            y = '0;
        end else if (|sh[IN_W-1:OUT_W-1]) begin
            y = {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            y = sh[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fc_feature_feeder.sv
// Buffers one frame of requantised features and streams it to the FC stage,
// then collects the FC class result.
//   state  | meaning
//   FILL   | accept features into the buffer
//   STREAM | present one LANES-wide group per cycle to the FC stage
//   WAIT   | hold FC enabled until fc_flag or timeout
//   DRAIN  | FC enable low for one cycle to clear its accumulators
module fc_feature_feeder
    import fc_pkg::*;
#(
    parameter int N_FEAT  = FC_N_FEAT,
    parameter int LANES   = FC_LANES,
    parameter int IN_W    = FC_IN_W,
    parameter int SHIFT   = FC_SHIFT,
    parameter int TIMEOUT = FC_TIMEOUT
) (
    input logic               clk,
    input logic               rst,
    fc_feature_feeder_if.master bus
);

    localparam int GROUPS = N_FEAT / LANES;
    localparam int AW     = clog2_min1(N_FEAT);
    localparam int RW     = clog2_min1(GROUPS);
    localparam int LW     = clog2_min1(LANES);
    localparam int TW     = clog2_min1(TIMEOUT + 1);

    fc_state_e                             state;
    logic [AW-1:0]                         wr_ptr;
    logic [RW-1:0]                         rd_idx;
    logic [TW-1:0]                         tmr;
    logic [FC_FEAT_W-1:0]                  fbuf [N_FEAT];
    logic [FC_FEAT_W-1:0]                  q_feat;
    logic signed [LANES-1:0][FC_FEAT_W-1:0] grp;
    logic                                  accept;

    feat_requant #(
        .IN_W  (IN_W),
        .SHIFT (SHIFT),
        .OUT_W (FC_FEAT_W)
    ) u_requant (
        .x (bus.feat_data),
        .y (q_feat)
    );

    assign accept         = (state == ST_FILL) && bus.feat_valid;
    assign bus.feat_ready = (state == ST_FILL) && !rst;
    assign bus.fc_en      = (state == ST_STREAM) || (state == ST_WAIT);

    // All lanes of a group read in the same cycle, hence a flop array.
    always_comb begin
        grp = '0;
        for (int i = 0; i < LANES; i++) begin
            grp[i] = fbuf[{rd_idx, LW'(i)}];
        end
    end

    assign bus.fc_in = (state == ST_STREAM) ? grp : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            fbuf[wr_ptr] <= q_feat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_FILL;
            wr_ptr           <= '0;
            rd_idx           <= '0;
            tmr              <= '0;
            bus.result_valid <= 1'b0;
            bus.result_class <= CLASS_NORMAL;
            bus.err          <= 1'b0;
        end else begin
            bus.result_valid <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (bus.feat_valid) begin
                        if (wr_ptr == AW'(N_FEAT - 1)) begin
                            wr_ptr <= '0;
                            rd_idx <= '0;
                            state  <= ST_STREAM;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (rd_idx == RW'(GROUPS - 1)) begin
                        rd_idx <= '0;
                        tmr    <= TW'(TIMEOUT - 1);
                        state  <= ST_WAIT;
                    end else begin
                        rd_idx <= rd_idx + 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A flag arriving on the last timeout cycle still counts as a result.
                    if (bus.fc_flag) begin
                        bus.result_class <= bus.fc_class;
                        bus.result_valid <= 1'b1;
                        state            <= ST_DRAIN;
                    end else if (tmr == '0) begin
                        bus.err <= 1'b1;
                        state   <= ST_DRAIN;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_FILL;
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule
